// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C line conditioner: idle bus level, default
// synchroniser depth and strobe-divider width, and the two-line state record.
// -----------------------------------------------------------------------------
package i2c_pkg;

   // An idle I2C bus is pulled up, so every reset value derives from this.
   localparam logic I2C_IDLE_LEVEL = 1'b1;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DIV_WIDTH   = 4;

   typedef struct packed {
      logic scl;
      logic sda;
   } line_state_t;

endpackage

// File: rtl/generic__maj3.sv
// -----------------------------------------------------------------------------
// generic__maj3
// Combinational 2-of-3 majority vote.
// Ports:
//   a, b, c : voter inputs
//   y       : 1 when at least two inputs are 1
// -----------------------------------------------------------------------------
module generic__maj3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);

   assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/i2c_line_sampler.sv
// -----------------------------------------------------------------------------
// i2c_line_sampler
// One bus line: a free-running metastability chain followed by a 3-bit sample
// window that only advances on the shared sample strobe.
// Ports:
//   clk    : system clock
//   rst    : synchronous reset, active-high (loads idle level everywhere)
//   pad    : raw asynchronous pad input
//   strobe : sample enable from the divider
//   window : last three strobed samples, newest in bit 0
// -----------------------------------------------------------------------------
module i2c_line_sampler
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pad,
   input  logic       strobe,
   output logic [2:0] window
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [2:0]             window_r;

   // Metastability chain; pad enters at bit 0, settled value leaves at the top.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
      end
   end

   // Sample window shifts in the synchronised level only on strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         window_r <= {3{I2C_IDLE_LEVEL}};
      end else if (strobe) begin
         window_r <= {window_r[1:0], sync_r[SYNC_STAGES-1]};
      end else begin
         window_r <= window_r;
      end
   end

   assign window = window_r;

endmodule

// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Input conditioner for the I2C target: synchronises SCL/SDA, samples them on
// a programmable strobe, majority-filters three samples per line and derives
// edge, START/STOP and bus-busy indications from the filtered levels.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active-high
//   scl_i     : raw SCL pad (asynchronous)
//   sda_i     : raw SDA pad (asynchronous)
//   cfg_div   : sample strobe period minus one
//   scl_o     : filtered SCL level
//   sda_o     : filtered SDA level
//   scl_rise  : one-cycle pulse, filtered SCL 0->1
//   scl_fall  : one-cycle pulse, filtered SCL 1->0
//   start_det : one-cycle pulse on START / repeated START
//   stop_det  : one-cycle pulse on STOP
//   bus_busy  : high from START until STOP
// All outputs are registered; pulses coincide with the new filtered level.
// -----------------------------------------------------------------------------
module i2c_line_filter
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DIV_WIDTH   = DEF_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 scl_i,
   input  logic                 sda_i,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 scl_o,
   output logic                 sda_o,
   output logic                 scl_rise,
   output logic                 scl_fall,
   output logic                 start_det,
   output logic                 stop_det,
   output logic                 bus_busy
);

   localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1'b1);

   logic [DIV_WIDTH-1:0] cnt_r;
   logic                 strobe_s;
   logic [2:0]           scl_win_s;
   logic [2:0]           sda_win_s;
   logic                 next_scl_s;
   logic                 next_sda_s;
   line_state_t          level_r;
   logic                 rise_s;
   logic                 fall_s;
   logic                 start_s;
   logic                 stop_s;
   logic                 busy_next_s;
   logic                 scl_rise_r;
   logic                 scl_fall_r;
   logic                 start_det_r;
   logic                 stop_det_r;
   logic                 bus_busy_r;

   // ">=" rather than "==" so that lowering cfg_div below the running count
   // fires on the next cycle instead of wrapping the counter.
   assign strobe_s = (cnt_r >= cfg_div);

   // Sample-strobe divider counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (strobe_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   i2c_line_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sampler (
      .clk    (clk),
      .rst    (rst),
      .pad    (scl_i),
      .strobe (strobe_s),
      .window (scl_win_s)
   );

   i2c_line_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sampler (
      .clk    (clk),
      .rst    (rst),
      .pad    (sda_i),
      .strobe (strobe_s),
      .window (sda_win_s)
   );

   generic__maj3 u_scl_maj (
      .a (scl_win_s[0]),
      .b (scl_win_s[1]),
      .c (scl_win_s[2]),
      .y (next_scl_s)
   );

   generic__maj3 u_sda_maj (
      .a (sda_win_s[0]),
      .b (sda_win_s[1]),
      .c (sda_win_s[2]),
      .y (next_sda_s)
   );

   // Edge / START / STOP / busy decode from current vs. next filtered levels.
   always_comb begin
      rise_s      = next_scl_s & ~level_r.scl;
      fall_s      = ~next_scl_s & level_r.scl;
      start_s     = 1'b0;
      stop_s      = 1'b0;
      busy_next_s = bus_busy_r;
      // SCL must be high both before and after; an SCL edge in the same
      // cycle as an SDA change is therefore never a START or STOP.
      if (level_r.scl && next_scl_s) begin
         start_s = level_r.sda & ~next_sda_s;
         stop_s  = ~level_r.sda & next_sda_s;
      end else begin
         start_s = 1'b0;
         stop_s  = 1'b0;
      end
      if (start_s) begin
         busy_next_s = 1'b1;
      end else if (stop_s) begin
         busy_next_s = 1'b0;
      end else begin
         busy_next_s = bus_busy_r;
      end
   end

   // Output registers: filtered levels, pulses and busy flag update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_r     <= '{scl: I2C_IDLE_LEVEL, sda: I2C_IDLE_LEVEL};
         scl_rise_r  <= 1'b0;
         scl_fall_r  <= 1'b0;
         start_det_r <= 1'b0;
         stop_det_r  <= 1'b0;
         bus_busy_r  <= 1'b0;
      end else begin
         level_r     <= '{scl: next_scl_s, sda: next_sda_s};
         scl_rise_r  <= rise_s;
         scl_fall_r  <= fall_s;
         start_det_r <= start_s;
         stop_det_r  <= stop_s;
         bus_busy_r  <= busy_next_s;
      end
   end

   assign scl_o     = level_r.scl;
   assign sda_o     = level_r.sda;
   assign scl_rise  = scl_rise_r;
   assign scl_fall  = scl_fall_r;
   assign start_det = start_det_r;
   assign stop_det  = stop_det_r;
   assign bus_busy  = bus_busy_r;

endmodule

// File: tb/tb_i2c_line_filter.sv
// -----------------------------------------------------------------------------
// tb_i2c_line_filter
// Self-checking bench for i2c_line_filter: a hand-derived vector table for
// latency and glitch behaviour, scripted bus sequences, and randomised pad
// activity compared every cycle against a sample-history reference model.
// -----------------------------------------------------------------------------
module tb_i2c_line_filter;

   localparam int S    = 2;
   localparam int DW   = 4;
   localparam int MAXC = 16384;
   localparam int NVEC = 38;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          scl_i = 1'b1;
   logic          sda_i = 1'b1;
   logic [DW-1:0] cfg_div = '0;
   logic          scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy;

   always #5 clk = ~clk;

   i2c_line_filter #(.SYNC_STAGES(S), .DIV_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .cfg_div   (cfg_div),
      .scl_o     (scl_o),
      .sda_o     (sda_o),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .bus_busy  (bus_busy)
   );

   int total = 0;
   int bad   = 0;

   // requested stimulus
   logic          scl_v = 1'b1;
   logic          sda_v = 1'b1;
   logic          rst_v = 1'b0;
   logic [DW-1:0] div_v = '0;

   // reference model: pad history per edge, last three strobed samples
   bit hs [MAXC];
   bit hd [MAXC];
   int cyc   = 0;
   int since = 0;
   bit qs[$];
   bit qd[$];
   bit m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0;
   bit m_rise = 1'b0, m_fall = 1'b0, m_start = 1'b0, m_stop = 1'b0;

   // event counters for scripted sequences
   int n_start = 0, n_stop = 0, n_rise = 0, n_fall = 0, n_sda_low = 0, n_busy_low = 0;

   typedef struct {
      bit         rst;
      bit         scl;
      bit         sda;
      logic [6:0] exp;   // {scl_o, sda_o, rise, fall, start, stop, busy}
   } vec_t;

   vec_t tbl [NVEC];

   function automatic bit vote(input bit q[$]);
      int ones = 0;
      foreach (q[i]) ones += int'(q[i]);
      return (ones >= 2);
   endfunction

   task automatic model_edge();
      bit ns, nd, smp_s, smp_d;
      hs[cyc] = scl_v;
      hd[cyc] = sda_v;
      if (rst_v) begin
         // the synchroniser reloads idle, so the last S pad samples read as 1
         for (int k = 0; k < S; k++) begin
            if (cyc - k >= 0) begin
               hs[cyc-k] = 1'b1;
               hd[cyc-k] = 1'b1;
            end
         end
         qs = '{1'b1, 1'b1, 1'b1};
         qd = '{1'b1, 1'b1, 1'b1};
         since = 0;
         m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0;
         m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0;
      end else begin
         ns = vote(qs);
         nd = vote(qd);
         m_rise  = ns && !m_scl;
         m_fall  = !ns && m_scl;
         m_start = m_scl && ns && m_sda && !nd;
         m_stop  = m_scl && ns && !m_sda && nd;
         if (m_start) m_busy = 1'b1;
         else if (m_stop) m_busy = 1'b0;
         m_scl = ns;
         m_sda = nd;
         if (since >= int'(div_v)) begin
            smp_s = (cyc - S >= 0) ? hs[cyc-S] : 1'b1;
            smp_d = (cyc - S >= 0) ? hd[cyc-S] : 1'b1;
            qs.push_back(smp_s); void'(qs.pop_front());
            qd.push_back(smp_d); void'(qd.pop_front());
            since = 0;
         end else begin
            since++;
         end
      end
      if (cyc < MAXC - 1) cyc++;
   endtask

   task automatic step();
      logic [6:0] got, exp;
      scl_i = scl_v; sda_i = sda_v; rst = rst_v; cfg_div = div_v;
      @(posedge clk);
      model_edge();
      #1;
      got = {scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy};
      exp = {m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL model cyc=%0d got=%b want=%b", cyc, got, exp);
      end
      n_start    += int'(start_det);
      n_stop     += int'(stop_det);
      n_rise     += int'(scl_rise);
      n_fall     += int'(scl_fall);
      n_sda_low  += int'(!sda_o);
      n_busy_low += int'(!bus_busy);
   endtask

   task automatic hold(input int n);
      repeat (n) step();
   endtask

   task automatic clr();
      n_start = 0; n_stop = 0; n_rise = 0; n_fall = 0; n_sda_low = 0; n_busy_low = 0;
   endtask

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   initial begin
      logic [6:0] got;
      qs = '{1'b1, 1'b1, 1'b1};
      qd = '{1'b1, 1'b1, 1'b1};

      // Vector table, cfg_div=0. Edge 0 is reset. SCL pad low over edges
      // 10..31 -> scl_o low over 14..35 with fall at 14 and rise at 36.
      // SDA 1-edge glitch at 18 is rejected; 2-edge low at 23,24 shows as
      // sda_o low at 27,28. SCL is low throughout, so no START/STOP.
      for (int i = 0; i < NVEC; i++) begin
         tbl[i].rst = (i == 0);
         tbl[i].scl = !(i >= 10 && i < 32);
         tbl[i].sda = !(i == 18 || i == 23 || i == 24);
         tbl[i].exp = {!(i >= 14 && i < 36), !(i == 27 || i == 28),
                       (i == 36), (i == 14), 3'b000};
      end

      div_v = 4'd0;
      for (int i = 0; i < NVEC; i++) begin
         rst_v = tbl[i].rst;
         scl_v = tbl[i].scl;
         sda_v = tbl[i].sda;
         step();
         got = {scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy};
         total++;
         if (got !== tbl[i].exp) begin
            bad++;
            $display("FAIL vec edge=%0d got=%b want=%b", i, got, tbl[i].exp);
         end
      end
      rst_v = 1'b0;
      hold(4);

      // START, data bits, repeated START, STOP
      clr();
      sda_v = 1'b0; hold(6);
      check("start_pulse", n_start, 1);
      check("busy_after_start", int'(bus_busy), 1);
      scl_v = 1'b0; hold(6);
      clr();
      for (int b = 0; b < 4; b++) begin
         sda_v = (b != 1); hold(3);
         scl_v = 1'b1; hold(6);
         scl_v = 1'b0; hold(6);
      end
      check("data_rise", n_rise, 4);
      check("data_fall", n_fall, 4);
      check("data_no_startstop", n_start + n_stop, 0);
      clr();
      sda_v = 1'b1; hold(3);
      scl_v = 1'b1; hold(6);
      sda_v = 1'b0; hold(6);
      check("rstart_pulse", n_start, 1);
      check("rstart_busy_kept", n_busy_low, 0);
      clr();
      scl_v = 1'b0; hold(6);
      sda_v = 1'b0; hold(3);
      scl_v = 1'b1; hold(6);
      sda_v = 1'b1; hold(6);
      check("stop_pulse", n_stop, 1);
      check("stop_no_start", n_start, 0);
      check("busy_after_stop", int'(bus_busy), 0);

      // reset in the middle of a transfer
      sda_v = 1'b0; hold(6);
      scl_v = 1'b0; hold(6);
      check("pre_reset_busy", int'(bus_busy), 1);
      check("pre_reset_scl", int'(scl_o), 0);
      rst_v = 1'b1; step();
      check("mid_reset_busy", int'(bus_busy), 0);
      check("mid_reset_scl", int'(scl_o), 1);
      check("mid_reset_stop", int'(stop_det), 0);
      rst_v = 1'b0; scl_v = 1'b1; sda_v = 1'b1;
      clr(); hold(10);
      check("post_reset_quiet", n_start + n_stop, 0);

      // divider cfg_div=3 with SCL parked low
      scl_v = 1'b0; hold(8);
      div_v = 4'd3; hold(8);
      clr();
      sda_v = 1'b0; hold(3);
      sda_v = 1'b1; hold(20);
      check("div3_glitch3_low", n_sda_low, 0);
      clr();
      sda_v = 1'b0; hold(8);
      sda_v = 1'b1; hold(30);
      check("div3_low8_len", n_sda_low, 8);
      scl_v = 1'b1; hold(12);

      // randomised pads, divider changes and resets against the model
      for (int it = 0; it < 600; it++) begin
         if ($urandom_range(0, 49) == 0) begin
            rst_v = 1'b1; step(); rst_v = 1'b0;
         end
         if ($urandom_range(0, 19) == 0) div_v = DW'($urandom_range(0, 3));
         scl_v = 1'($urandom_range(0, 1));
         sda_v = 1'($urandom_range(0, 1));
         hold($urandom_range(1, 6));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_line_filter.md
Name: i2c_line_filter

Overview:
Input conditioner for the I2C BERT target. It synchronises the raw SCL/SDA pad inputs and samples them on a programmable strobe. Each line is glitch-filtered by 2-of-3 majority voting over its last three samples. It emits filtered levels, SCL edge pulses, START/STOP pulses and a bus-busy flag. The filtered levels and pulses feed the I2C protocol engine.

Parameters:
SYNC_STAGES, 2, number of metastability flops per line (minimum 2).
DIV_WIDTH, 4, width of the sample-strobe divider input and counter.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
scl_i  input  1  raw SCL from pad (asynchronous)
sda_i  input  1  raw SDA from pad (asynchronous)
cfg_div  input  DIV_WIDTH  sample strobe period minus one
scl_o  output  1  filtered SCL level
sda_o  output  1  filtered SDA level
scl_rise  output  1  one-cycle pulse on filtered SCL 0->1
scl_fall  output  1  one-cycle pulse on filtered SCL 1->0
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP
bus_busy  output  1  high from START until STOP

Behaviour:
- Reset (rst=1 at an edge) loads the idle-bus state:
  - sync flops = 1; sample windows = 3'b111; divider counter = 0.
  - scl_o = sda_o = 1; all pulses = 0; bus_busy = 0.
  - Reset mid-transfer discards all pending state. No STOP pulse is generated.
- Synchroniser: SYNC_STAGES flops per line, free-running every clk.
- Divider: counter increments each clk.
  - strobe = (counter >= cfg_div); the counter clears to 0 on strobe.
  - cfg_div = 0 gives a strobe every cycle.
  - Lowering cfg_div below the current count gives a strobe on the next cycle, then the new period.
- Window: on strobe, each line's 3-bit window shifts left and takes the synchroniser output. There is no shift without strobe.
- Filter: next_level = maj3(window). scl_o/sda_o register next_level every clk.
- Latency, cfg_div = 0: a step first captured at edge N appears on scl_o/sda_o at edge N+SYNC_STAGES+2 (N+4 by default).
- Glitch rejection: a deviation lasting one strobe is rejected. A deviation lasting two or more strobes passes.
- Pulses are registered and high in the same cycle the new filtered level is visible.
  - scl_rise = (next_scl & ~scl_o).
  - scl_fall = (~next_scl & scl_o).
- START: next_sda=0, sda_o=1, next_scl=1, scl_o=1.
- STOP: next_sda=1, sda_o=0, next_scl=1, scl_o=1.
- Simultaneous SCL and SDA change in the same cycle: no START/STOP. The SCL edge pulse still fires.
- bus_busy:
  - set on start_det; cleared on stop_det; a repeated START keeps it at 1.
  - START and STOP cannot coincide.
- STOP while not busy: stop_det still pulses; bus_busy stays 0.

Decomposition:
- Package i2c_pkg holds:
  - I2C_IDLE_LEVEL = 1'b1;
  - default SYNC_STAGES and DIV_WIDTH;
  - a line_state_t struct {scl, sda}.
- Sub-module: reuse the existing generic__maj3 cell, one instance per line, fed by the window bits.
- A per-line synchroniser-plus-window sub-module, i2c_line_sampler, is natural. Instantiate it twice.

Test Plan:
1. Reset, hold both lines at 1, cfg_div=0 -> scl_o=sda_o=1, no pulses, bus_busy=0 for 20 cycles.
2. Sample timing, cfg_div=0:
   - step scl_i 1->0 at edge 10 -> scl_o=0 and scl_fall=1 exactly at edge 14;
   - scl_fall is 0 at edges 13 and 15.
3. Glitch, cfg_div=0:
   - 1-cycle sda_i low pulse -> sda_o stays 1, no pulses;
   - 2-cycle low pulse -> sda_o low for 2 cycles.
4. Divider, cfg_div=3:
   - 3-cycle glitch -> rejected;
   - 8-cycle low -> passes;
   - strobe observed every 4 clks.
5. Bus sequence:
   - SDA falls with SCL high -> start_det pulse, bus_busy=1;
   - data clocks -> matching rise/fall pulses;
   - repeated START -> start_det, busy stays 1;
   - STOP -> stop_det, busy=0.
6. Reset mid-transfer: assert rst with bus_busy=1 and SCL low -> next cycle bus_busy=0, scl_o=1, no stop_det.
